// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stall bit positions,
// exception codes, FSM state encoding and the redirect-PC helper.
package pipeline_hazard_ctrl_pkg;

    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic [5:0] STALL_NONE     = 6'b000000;
    localparam logic [5:0] STALL_LOAD_USE = 6'b000111;
    localparam logic [5:0] STALL_MC       = 6'b001111;

    localparam logic [31:0] EXC_NONE      = 32'h0000_0000;
    localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
    localparam logic [31:0] EXC_INVALID   = 32'h0000_000A;
    localparam logic [31:0] EXC_OVERFLOW  = 32'h0000_000C;
    localparam logic [31:0] EXC_ERET      = 32'h0000_000E;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MC_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } hz_state_e;

    // ERET returns to EPC; every other exception enters the common vector.
    function automatic logic [31:0] redirect_pc(input logic [31:0] exc_type,
                                                input logic [31:0] epc,
                                                input logic [31:0] vector);
        logic [31:0] pc;
        if (exc_type == EXC_ERET) begin
            pc = epc;
        end else begin
            pc = vector;
        end
        return pc;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the hazard controller (master) and the pipeline
// stages it sequences (slave).
interface pipeline_hazard_ctrl_if;
    logic        ex_is_load;
    logic [4:0]  ex_w_dest;
    logic        id_reg1_read;
    logic [4:0]  id_reg1_addr;
    logic        id_reg2_read;
    logic [4:0]  id_reg2_addr;
    logic        ex_mc_start;
    logic        ex_mc_done;
    logic [31:0] mem_excepttype;
    logic [31:0] cp0_epc;
    logic [5:0]  stall;
    logic        bubble_ex;
    logic        bubble_mem;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_abort;

    modport master (
        input  ex_is_load, ex_w_dest, id_reg1_read, id_reg1_addr,
               id_reg2_read, id_reg2_addr, ex_mc_start, ex_mc_done,
               mem_excepttype, cp0_epc,
        output stall, bubble_ex, bubble_mem, flush, new_pc, mc_abort
    );

    modport slave (
        output ex_is_load, ex_w_dest, id_reg1_read, id_reg1_addr,
               id_reg2_read, id_reg2_addr, ex_mc_start, ex_mc_done,
               mem_excepttype, cp0_epc,
        input  stall, bubble_ex, bubble_mem, flush, new_pc, mc_abort
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_lu_detect.sv
// Load-use compare: an ID source matches the destination of a load in EX.
// Register $0 is hardwired to zero, so it never creates a dependency.
module pipeline_hazard_ctrl_lu_detect (
    input  logic       ex_is_load,
    input  logic [4:0] ex_w_dest,
    input  logic       id_reg1_read,
    input  logic [4:0] id_reg1_addr,
    input  logic       id_reg2_read,
    input  logic [4:0] id_reg2_addr,
    output logic       lu_hazard
);
    logic rs_hit_s;
    logic rt_hit_s;

    assign rs_hit_s  = id_reg1_read && (id_reg1_addr == ex_w_dest);
    assign rt_hit_s  = id_reg2_read && (id_reg2_addr == ex_w_dest);
    assign lu_hazard = ex_is_load && (ex_w_dest != 5'd0) && (rs_hit_s || rt_hit_s);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, multi-cycle
// EX hold with watchdog, exception flush. HAZARD_PERF_CNT_EN adds perf counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
    parameter int          MC_TIMEOUT = 64,
    parameter int          CNT_W      = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.master hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]            perf_lu_cnt,
    output logic [31:0]            perf_mc_cnt,
    output logic [31:0]            perf_flush_cnt
`endif
);

    hz_state_e        state_r;
    hz_state_e        state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic             lu_hazard_s;
    logic             exc_s;
    logic             timeout_s;

    pipeline_hazard_ctrl_lu_detect u_lu_detect (
        .ex_is_load   (hz.ex_is_load),
        .ex_w_dest    (hz.ex_w_dest),
        .id_reg1_read (hz.id_reg1_read),
        .id_reg1_addr (hz.id_reg1_addr),
        .id_reg2_read (hz.id_reg2_read),
        .id_reg2_addr (hz.id_reg2_addr),
        .lu_hazard    (lu_hazard_s)
    );

    assign exc_s     = (hz.mem_excepttype != EXC_NONE);
    assign timeout_s = (cnt_r == CNT_W'(MC_TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Watchdog counter: counts consecutive MC_WAIT cycles, zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_MC_WAIT) && (state_next_s == ST_MC_WAIT)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Next-state logic; an exception overrides everything and cancels MC_WAIT.
    always_comb begin
        state_next_s = state_r;
        if (exc_s) begin
            state_next_s = ST_FLUSH;
        end else begin
            case (state_r)
                ST_IDLE:    state_next_s = hz.ex_mc_start ? ST_MC_WAIT : ST_IDLE;
                ST_MC_WAIT: state_next_s = (hz.ex_mc_done || timeout_s) ? ST_IDLE : ST_MC_WAIT;
                ST_FLUSH:   state_next_s = ST_IDLE;
                default:    state_next_s = ST_IDLE;
            endcase
        end
    end

    // Output decode; outputs are forced quiet for the whole reset window.
    always_comb begin
        hz.stall      = STALL_NONE;
        hz.bubble_ex  = 1'b0;
        hz.bubble_mem = 1'b0;
        hz.flush      = 1'b0;
        hz.new_pc     = 32'h0000_0000;
        hz.mc_abort   = 1'b0;
        if (rst) begin
            hz.flush = 1'b0;
        end else if (exc_s) begin
            hz.flush  = 1'b1;
            hz.new_pc = redirect_pc(hz.mem_excepttype, hz.cp0_epc, EXC_VECTOR);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (lu_hazard_s) begin
                        hz.stall     = STALL_LOAD_USE;
                        hz.bubble_ex = 1'b1;
                    end else begin
                        hz.stall = STALL_NONE;
                    end
                end
                ST_MC_WAIT: begin
                    // Done releases the hold and takes priority over the watchdog.
                    if (hz.ex_mc_done) begin
                        hz.stall = STALL_NONE;
                    end else if (timeout_s) begin
                        hz.mc_abort = 1'b1;
                    end else begin
                        hz.stall      = STALL_MC;
                        hz.bubble_mem = 1'b1;
                    end
                end
                ST_FLUSH: hz.stall = STALL_NONE;
                default:  hz.stall = STALL_NONE;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Event counters for load-use stalls, multi-cycle holds and flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lu_cnt    <= 32'h0000_0000;
            perf_mc_cnt    <= 32'h0000_0000;
            perf_flush_cnt <= 32'h0000_0000;
        end else begin
            perf_lu_cnt    <= perf_lu_cnt + {31'h0000_0000, hz.bubble_ex};
            perf_mc_cnt    <= perf_mc_cnt + {31'h0000_0000, (hz.stall == STALL_MC)};
            perf_flush_cnt <= perf_flush_cnt + {31'h0000_0000, hz.flush};
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected outputs come from a
// behavioural model, queued at drive time and checked at the falling edge.
module tb_pipeline_hazard_ctrl;
    localparam int MC_TIMEOUT = 64;
    localparam int S_IDLE = 0, S_MC = 1, S_FLUSH = 2;

    logic clk;
    logic rst;
    pipeline_hazard_ctrl_if hif();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu_cnt, perf_mc_cnt, perf_flush_cnt;
    int unsigned m_lu, m_mc, m_fl;
`endif

    pipeline_hazard_ctrl #(
        .EXC_VECTOR (32'h0000_0040),
        .MC_TIMEOUT (MC_TIMEOUT),
        .CNT_W      (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_lu_cnt    (perf_lu_cnt),
        .perf_mc_cnt    (perf_mc_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stall, bubble_ex, bubble_mem, flush, mc_abort, new_pc}
    logic [41:0] exp_q[$];
    int vectors = 0;
    int errors  = 0;
    int m_state = S_IDLE;
    int m_cnt   = 0;

    task automatic step(input logic r, input logic ld, input logic [4:0] wd,
                        input logic r1, input logic [4:0] a1,
                        input logic r2, input logic [4:0] a2,
                        input logic st, input logic dn,
                        input logic [31:0] exc, input logic [31:0] epc,
                        input string tag);
        logic [5:0]  e_stall;
        logic        e_bex, e_bmem, e_fl, e_ab, lu;
        logic [31:0] e_pc;
        logic [41:0] obs, expv;
        int          n_state, n_cnt;
        rst = r;
        hif.ex_is_load = ld;   hif.ex_w_dest = wd;
        hif.id_reg1_read = r1; hif.id_reg1_addr = a1;
        hif.id_reg2_read = r2; hif.id_reg2_addr = a2;
        hif.ex_mc_start = st;  hif.ex_mc_done = dn;
        hif.mem_excepttype = exc; hif.cp0_epc = epc;
        e_stall = 6'b000000; e_bex = 1'b0; e_bmem = 1'b0;
        e_fl = 1'b0; e_ab = 1'b0; e_pc = 32'h0;
        n_state = S_IDLE; n_cnt = 0;
        lu = ld && (wd != 5'd0) && ((r1 && a1 == wd) || (r2 && a2 == wd));
        if (r) begin
            n_state = S_IDLE;
        end else if (exc != 32'h0) begin
            e_fl = 1'b1;
            e_pc = (exc == 32'hE) ? epc : 32'h0000_0040;
            n_state = S_FLUSH;
        end else if (m_state == S_MC) begin
            if (dn) begin
                n_state = S_IDLE;
            end else if (m_cnt == MC_TIMEOUT - 1) begin
                e_ab = 1'b1;
                n_state = S_IDLE;
            end else begin
                e_stall = 6'b001111; e_bmem = 1'b1;
                n_state = S_MC; n_cnt = m_cnt + 1;
            end
        end else if (m_state == S_IDLE) begin
            if (lu) begin
                e_stall = 6'b000111; e_bex = 1'b1;
            end
            n_state = st ? S_MC : S_IDLE;
        end
        exp_q.push_back({e_stall, e_bex, e_bmem, e_fl, e_ab, e_pc});
`ifdef HAZARD_PERF_CNT_EN
        if (!r) begin
            m_lu += int'(e_bex); m_mc += int'(e_bmem); m_fl += int'(e_fl);
        end
`endif
        @(negedge clk);
        obs  = {hif.stall, hif.bubble_ex, hif.bubble_mem, hif.flush, hif.mc_abort, hif.new_pc};
        expv = exp_q.pop_front();
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
        @(posedge clk);
        m_state = n_state;
        m_cnt   = n_cnt;
        #1;
    endtask

    task automatic quiet(input int n, input string tag);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, tag);
    endtask

    task automatic start_mc(input string tag);
        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, tag);
    endtask

    // Load-use pattern on rt=$5; stalls only when the FSM is IDLE.
    task automatic lu_probe(input string tag);
        step(1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 32'h0, 32'h0, tag);
    endtask

    initial begin
        rst = 1'b1;
        hif.ex_is_load = 1'b0; hif.ex_w_dest = 5'd0;
        hif.id_reg1_read = 1'b0; hif.id_reg1_addr = 5'd0;
        hif.id_reg2_read = 1'b0; hif.id_reg2_addr = 5'd0;
        hif.ex_mc_start = 1'b0; hif.ex_mc_done = 1'b0;
        hif.mem_excepttype = 32'h0; hif.cp0_epc = 32'h0;
        @(posedge clk); #1;

        // Reset: quiet outputs even with a hazard and an exception present.
        step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, "reset_idle");
        step(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 32'hC, 32'h0, "reset_masks");
        quiet(1, "post_reset");

        // Load-use detection.
        lu_probe("lu_rt");
        step(1'b0, 1'b0, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 32'h0, 32'h0, "lu_released");
        step(1'b0, 1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, "lu_rs");
        step(1'b0, 1'b1, 5'd9, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, "lu_no_read");
        step(1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, "lu_r0");
        step(1'b0, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 5'd8, 1'b0, 1'b0, 32'h0, 32'h0, "lu_diff");

        // DIV: ten held cycles, released in the done cycle, then IDLE again.
        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0, 32'h0, "done_in_idle");
        start_mc("div_start");
        quiet(4, "div_wait");
        lu_probe("div_no_lu");
        quiet(5, "div_wait");
        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0, 32'h0, "div_done");
        lu_probe("div_idle");

        // Watchdog: abort on MC_WAIT cycle 64, then IDLE.
        start_mc("wd_start");
        quiet(MC_TIMEOUT, "wd_wait");
        quiet(1, "wd_after");
        lu_probe("wd_idle");

        // Done and timeout together: done wins, no abort.
        start_mc("wd2_start");
        quiet(MC_TIMEOUT - 1, "wd2_wait");
        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0, 32'h0, "done_vs_timeout");
        quiet(1, "wd2_after");

        // Overflow during MC_WAIT; start and hazard are ignored around the flush.
        start_mc("exc_start");
        quiet(3, "exc_wait");
        step(1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 32'hC, 32'h0, "exc_flush");
        step(1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0, "flush_state");
        quiet(1, "exc_no_mc");
        lu_probe("exc_idle");

        // ERET and other exception codes.
        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'hE, 32'hBFC0_0100, "eret");
        quiet(1, "eret_flush_state");
        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h8, 32'hBFC0_0100, "syscall");
        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h1, 32'h1234_5678, "int_in_flush");
        quiet(1, "int_after");

        // Reset in the middle of MC_WAIT: quiet at once, no abort, IDLE after release.
        start_mc("rst_start");
        quiet(3, "rst_wait");
        step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, "rst_mid_mc");
        step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, "rst_hold");
        lu_probe("rst_idle");
        quiet(1, "rst_after");

`ifdef HAZARD_PERF_CNT_EN
        vectors++;
        assert (perf_lu_cnt === m_lu) else begin
            errors++; $error("FAIL perf_lu: observed %0d expected %0d", perf_lu_cnt, m_lu);
        end
        vectors++;
        assert (perf_mc_cnt === m_mc) else begin
            errors++; $error("FAIL perf_mc: observed %0d expected %0d", perf_mc_cnt, m_mc);
        end
        vectors++;
        assert (perf_flush_cnt === m_fl) else begin
            errors++; $error("FAIL perf_flush: observed %0d expected %0d", perf_flush_cnt, m_fl);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Detects load-use hazards that forwarding cannot resolve (the EX-stage load result is not ready until MEM).
- Holds the front of the pipeline while a multi-cycle EX operation (DIV/MULT) runs, with a watchdog on that operation.
- Converts a committed MEM-stage exception into a one-cycle flush plus a redirect PC.
- Drives the ID/EX register's stall/flush inputs, whose meaning is "load bubble".

Parameters:
- EXC_VECTOR, 32'h0000_0040: redirect PC for all exceptions except ERET.
- MC_TIMEOUT, 64: maximum cycles in MC_WAIT before a forced abort.
- CNT_W, 7: width of the MC watchdog counter; must satisfy 2^CNT_W > MC_TIMEOUT.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- ex_is_load  in  1  instruction in EX is a load
- ex_w_dest  in  5  EX destination register address
- id_reg1_read  in  1  ID reads rs
- id_reg1_addr  in  5  ID rs address
- id_reg2_read  in  1  ID reads rt
- id_reg2_addr  in  5  ID rt address
- ex_mc_start  in  1  EX begins a multi-cycle op (1-cycle pulse)
- ex_mc_done  in  1  multi-cycle result valid (1-cycle pulse)
- mem_excepttype  in  32  committed exception type; 0 = none
- cp0_epc  in  32  EPC value for ERET
- stall  out  6  hold enables {wb,mem,ex,id,if,pc} (bit0 = pc)
- bubble_ex  out  1  to ID/EX stall: load NOP into EX
- bubble_mem  out  1  load NOP into EX/MEM
- flush  out  1  clear all pipeline registers
- new_pc  out  32  redirect target, valid while flush=1
- mc_abort  out  1  1-cycle pulse: watchdog expired, EX unit must reset

Behaviour:
- State machine: IDLE, MC_WAIT, FLUSH. Registered state and counter; all outputs are combinational from state and inputs.
- While rst is high:
  - state = IDLE, counter = 0.
  - All outputs 0, including new_pc.
  - Reset asserted mid-MC_WAIT abandons the operation; no mc_abort pulse.
- Priority: exception > multi-cycle wait > load-use > none.
- Exception (mem_excepttype != 0), in any state:
  - Same cycle: flush=1; stall=0; bubble_ex=0; bubble_mem=0.
  - new_pc = cp0_epc if mem_excepttype == 32'h0000_000E (ERET), else EXC_VECTOR.
  - Next state is FLUSH, which lasts exactly one cycle. In FLUSH all outputs are 0, then the FSM returns to IDLE.
  - A pending MC_WAIT is cancelled and the counter cleared.
  - Any ex_mc_start or load-use condition in the flush cycle is ignored.
- Load-use, IDLE only: the condition is `ex_is_load && ex_w_dest != 0` and either:
  - id_reg1_read && id_reg1_addr == ex_w_dest, or
  - id_reg2_read && id_reg2_addr == ex_w_dest.
  - Response, same cycle: stall = 6'b000111 and bubble_ex = 1, for exactly one cycle.
  - No state change; the next cycle re-evaluates naturally because the load has moved to MEM.
- Multi-cycle: ex_mc_start in IDLE with no exception moves to MC_WAIT next cycle and clears the counter.
  - In MC_WAIT: stall = 6'b001111; bubble_mem = 1; the counter increments each cycle.
  - ex_mc_done in MC_WAIT: stall=0 that same cycle (EX result is captured), and next state is IDLE.
  - Counter reaching MC_TIMEOUT-1 without done: mc_abort=1, stall=0, next state IDLE. This is an abort, not a flush.
  - ex_mc_done and timeout in the same cycle: done wins and mc_abort=0.
  - ex_mc_done in IDLE is ignored.
  - Load-use is not evaluated in MC_WAIT.
- ex_w_dest == 0 never causes a stall.

Optional Feature:
- HAZARD_PERF_CNT_EN
- Defined:
  - Adds outputs perf_lu_cnt[31:0], perf_mc_cnt[31:0], perf_flush_cnt[31:0].
  - Counters increment once per load-use stall cycle, MC_WAIT stall cycle, and flush cycle respectively.
  - Async reset to 0; each wraps at 2^32.
- Undefined: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared defines header (existing global defines):
  - Stall vector bit positions.
  - Exception codes: ERET = 32'hE, SYSCALL = 32'h8, INVALID = 32'hA, OVERFLOW = 32'hC, INTERRUPT = 32'h1.
  - FSM state encodings: 2-bit, IDLE = 0, MC_WAIT = 1, FLUSH = 2.
- Sub-module lu_detect: a purely combinational compare of ID sources against the EX load destination, kept separate for unit test.

Test Plan:
- Load-use: ex_is_load=1, ex_w_dest=5, id_reg2_read=1, id_reg2_addr=5 → stall=6'b000111 and bubble_ex=1 for one cycle; 0 the next cycle after ex_is_load drops.
- Load to $0: ex_w_dest=0, id_reg1_addr=0 → stall=0, bubble_ex=0.
- DIV: ex_mc_start pulse, ex_mc_done pulses 10 cycles later → stall=6'b001111 for 10 cycles, 0 in the done cycle, FSM back in IDLE.
- Watchdog: ex_mc_start, no done → mc_abort=1 exactly on cycle 64 of MC_WAIT, then IDLE with stall=0.
- Exception during MC_WAIT: mem_excepttype=32'hC → flush=1, new_pc=32'h40, stall=0; next cycle all outputs 0; the following cycle IDLE.
- ERET: mem_excepttype=32'hE, cp0_epc=32'hBFC0_0100 → flush=1, new_pc=32'hBFC0_0100. Assert rst mid-MC_WAIT → all outputs 0 immediately, IDLE after release.
